regfile_sb: RTL and testbench

Parametrised 2-read/1-write integer register file with a per-register busy scoreboard and a sequenced bulk-clear engine, for the multi-cycle and pipelined RV32I cores. Register 0 is hardwired to zero. Reads are combinational; writes, scoreboard updates and the clear sweep are synchronous to the single clock. The scoreboard lets issue logic detect RAW hazards against in-flight writebacks without its own tracking.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/regfile_sb.sv | 156 +++++++++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file types and default sizes.
// Imported by regfile_sb, rf_scoreboard and the core's decode/issue logic.
package rf_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_SWEEP = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending-writeback bit per register.
// A reserve beats a same-cycle release; a bulk clear beats both.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr_all,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_rel_en,
    input  logic [AW-1:0] i_rel_idx,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    output logic          o_busy_a,
    output logic          o_busy_b
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Next busy vector: release first, then reserve, clear overrides all.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_rel_en) begin
            w_busy_nxt[i_rel_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        if (i_clr_all) begin
            w_busy_nxt = '0;
        end
    end

    // Busy vector register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Lookup ports; bit 0 is never set so x0 always reads idle.
    always_comb begin
        o_busy_a = r_busy[i_ra];
        o_busy_b = r_busy[i_rb];
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with busy scoreboard and bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int XLEN = RF_XLEN,
    parameter  int NREG = RF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            wrclk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic [XLEN-1:0] outa,
    output logic [XLEN-1:0] outb,
    output logic            busy_a,
    output logic            busy_b,
    input  logic            rsv,
    input  logic [AW-1:0]   rsv_rd,
    output logic            rsv_ok,
    input  logic            regwr,
    input  logic [AW-1:0]   rw,
    input  logic [XLEN-1:0] wrdata,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

    rf_state_e       r_state;
    logic [AW-1:0]   r_idx;
    logic            r_clr_busy;
    logic            r_clr_done;
    logic [XLEN-1:0] r_regs [NREG];

    logic            w_idle;
    logic            w_wr_en;
    logic            w_rsv_en;
    logic            w_clr_start;
    logic            w_sweep_en;
    logic            w_sb_busy_a;
    logic            w_sb_busy_b;
    logic [XLEN-1:0] w_outa;
    logic [XLEN-1:0] w_outb;
    logic            w_busy_a;
    logic            w_busy_b;

    // Port-side enables; everything is frozen while a sweep runs.
    always_comb begin
        w_idle      = (r_state == RF_IDLE);
        w_wr_en     = regwr && (rw != '0) && w_idle;
        w_rsv_en    = rsv && (rsv_rd != '0) && w_idle;
        w_clr_start = clr_req && w_idle;
        w_sweep_en  = (r_state == RF_SWEEP);
    end

    // Clear sequencer: IDLE -> SWEEP (x1..xN-1) -> DONE -> IDLE.
    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RF_IDLE;
            r_idx      <= IDX_ONE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            unique case (r_state)
                RF_IDLE: begin
                    if (clr_req) begin
                        r_state    <= RF_SWEEP;
                        r_idx      <= IDX_ONE;
                        r_clr_busy <= 1'b1;
                    end
                end
                RF_SWEEP: begin
                    if (r_idx == IDX_LAST) begin
                        r_state    <= RF_DONE;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                RF_DONE: begin
                    r_state    <= RF_IDLE;
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b0;
                end
                default: begin
                    r_state    <= RF_IDLE;
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Data array: sweep zeroes one entry per cycle, else normal writeback.
    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_sweep_en) begin
            r_regs[r_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[rw] <= wrdata;
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .i_clk     (wrclk),
        .i_rst_n   (rst_n),
        .i_clr_all (w_clr_start),
        .i_set_en  (w_rsv_en),
        .i_set_idx (rsv_rd),
        .i_rel_en  (w_wr_en),
        .i_rel_idx (rw),
        .i_ra      (ra),
        .i_rb      (rb),
        .o_busy_a  (w_sb_busy_a),
        .o_busy_b  (w_sb_busy_b)
    );

    // Read ports: x0 pinned to zero, optional writeback forwarding.
    always_comb begin
        w_outa   = (ra == '0) ? '0 : r_regs[ra];
        w_outb   = (rb == '0) ? '0 : r_regs[rb];
        w_busy_a = w_sb_busy_a;
        w_busy_b = w_sb_busy_b;
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (rw == ra)) begin
            w_outa   = wrdata;
            w_busy_a = 1'b0;
        end
        if (w_wr_en && (rw == rb)) begin
            w_outb   = wrdata;
            w_busy_b = 1'b0;
        end
`endif
    end

    // Output drive.
    always_comb begin
        outa     = w_outa;
        outb     = w_outb;
        busy_a   = w_busy_a;
        busy_b   = w_busy_b;
        rsv_ok   = w_rsv_en;
        clr_busy = r_clr_busy;
        clr_done = r_clr_done;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb
// against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            wrclk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   ra, rb, rsv_rd, rw;
    logic [XLEN-1:0] outa, outb, wrdata;
    logic            busy_a, busy_b, rsv, rsv_ok, regwr;
    logic            clr_req, clr_busy, clr_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    always #5 wrclk = ~wrclk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .wrclk    (wrclk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rb       (rb),
        .outa     (outa),
        .outb     (outb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .rsv      (rsv),
        .rsv_rd   (rsv_rd),
        .rsv_ok   (rsv_ok),
        .regwr    (regwr),
        .rw       (rw),
        .wrdata   (wrdata),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic idle_inputs();
        rsv = 0; rsv_rd = '0; regwr = 0; rw = '0;
        wrdata = '0; clr_req = 0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    // Model update for the coming edge (register file idle).
    task automatic model_edge();
        if (regwr && rw != 0) begin
            m_regs[rw] = wrdata;
            m_busy[rw] = 0;
        end
        if (rsv && rsv_rd != 0) m_busy[rsv_rd] = 1;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (BYP && regwr && rw != 0 && rw == idx) return wrdata;
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] idx);
        if (idx == 0) return 1'b0;
        if (BYP && regwr && rw != 0 && rw == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    task automatic fill_all();
        for (int i = 1; i < NREG; i++) begin
            regwr = 1; rw = AW'(i);
            wrdata = $urandom() | 32'h1;
            model_edge();
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_zero();
        ra = AW'($urandom()); rb = AW'($urandom());
        repeat (3) tick();
        n_tests++; if (outa !== '0) begin n_fail++; $display("FAIL rst_outa: got %h want 0", outa); end
        n_tests++; if (outb !== '0) begin n_fail++; $display("FAIL rst_outb: got %h want 0", outb); end
        n_tests++; if (busy_a !== 0 || busy_b !== 0) begin n_fail++; $display("FAIL rst_busy: got %b%b want 00", busy_a, busy_b); end
        n_tests++; if (rsv_ok !== 0) begin n_fail++; $display("FAIL rst_rsv_ok: got %b want 0", rsv_ok); end
        n_tests++; if (clr_busy !== 0 || clr_done !== 0) begin n_fail++; $display("FAIL rst_clr: got %b%b want 00", clr_busy, clr_done); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_read();
        logic [XLEN-1:0] exp;
        regwr = 1; rw = 5; wrdata = 32'hDEADBEEF; ra = 5;
        #1;
        exp = BYP ? 32'hDEADBEEF : 32'h0;
        n_tests++; if (outa !== exp) begin n_fail++; $display("FAIL wr_pre_edge: got %h want %h", outa, exp); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (outa !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_post_edge: got %h want deadbeef", outa); end
        regwr = 1; rw = 0; wrdata = 32'hFFFFFFFF; rb = 0;
        #1;
        n_tests++; if (outb !== '0) begin n_fail++; $display("FAIL wr_x0_pre: got %h want 0", outb); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (outb !== '0) begin n_fail++; $display("FAIL wr_x0_post: got %h want 0", outb); end
    endtask

    task automatic test_scoreboard();
        rsv = 1; rsv_rd = 7; ra = 7;
        #1;
        n_tests++; if (rsv_ok !== 1) begin n_fail++; $display("FAIL sb_rsv_ok: got %b want 1", rsv_ok); end
        n_tests++; if (busy_a !== 0) begin n_fail++; $display("FAIL sb_busy_pre: got %b want 0", busy_a); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_a !== 1) begin n_fail++; $display("FAIL sb_busy_set: got %b want 1", busy_a); end
        regwr = 1; rw = 7; wrdata = 32'h12;
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_a !== 0) begin n_fail++; $display("FAIL sb_release: got %b want 0", busy_a); end
        n_tests++; if (outa !== 32'h12) begin n_fail++; $display("FAIL sb_data: got %h want 12", outa); end
        rsv = 1; rsv_rd = 7; regwr = 1; rw = 7; wrdata = 32'h12;
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_a !== 1) begin n_fail++; $display("FAIL sb_waw_busy: got %b want 1", busy_a); end
        n_tests++; if (outa !== 32'h12) begin n_fail++; $display("FAIL sb_waw_data: got %h want 12", outa); end
        rsv = 1; rsv_rd = 7;
        #1;
        n_tests++; if (rsv_ok !== 1) begin n_fail++; $display("FAIL sb_rersv_ok: got %b want 1", rsv_ok); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_a !== 1) begin n_fail++; $display("FAIL sb_rersv_busy: got %b want 1", busy_a); end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_d;
        logic            exp_b;
        regwr = 1; rw = 3; wrdata = 32'h11111111; rsv = 1; rsv_rd = 3;
        model_edge();
        tick();
        idle_inputs();
        regwr = 1; rw = 3; wrdata = 32'hA5A5A5A5; ra = 3; rb = 3;
        rsv = 1; rsv_rd = 3;
        #1;
        exp_d = BYP ? 32'hA5A5A5A5 : 32'h11111111;
        exp_b = BYP ? 1'b0 : 1'b1;
        n_tests++; if (outa !== exp_d) begin n_fail++; $display("FAIL byp_outa: got %h want %h", outa, exp_d); end
        n_tests++; if (outb !== exp_d) begin n_fail++; $display("FAIL byp_outb: got %h want %h", outb, exp_d); end
        n_tests++; if (busy_a !== exp_b) begin n_fail++; $display("FAIL byp_busy_a: got %b want %b", busy_a, exp_b); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (outa !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byp_after: got %h want a5a5a5a5", outa); end
        n_tests++; if (busy_a !== 1) begin n_fail++; $display("FAIL byp_rsv_wins: got %b want 1", busy_a); end
    endtask

    task automatic test_rsv_zero();
        rsv = 1; rsv_rd = 0; ra = 0;
        #1;
        n_tests++; if (rsv_ok !== 0) begin n_fail++; $display("FAIL rsv0_ok: got %b want 0", rsv_ok); end
        model_edge();
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_a !== 0) begin n_fail++; $display("FAIL rsv0_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ea, eb;
        logic            eba, ebb, eok;
        for (int n = 0; n < 400; n++) begin
            regwr  = ($urandom_range(1) == 1);
            rw     = AW'($urandom());
            wrdata = $urandom();
            rsv    = ($urandom_range(2) == 0);
            rsv_rd = ($urandom_range(3) == 0) ? rw : AW'($urandom());
            ra     = ($urandom_range(3) == 0) ? rw : AW'($urandom());
            rb     = ($urandom_range(3) == 0) ? rw : AW'($urandom());
            #1;
            ea = exp_data(ra); eb = exp_data(rb);
            eba = exp_busy(ra); ebb = exp_busy(rb);
            eok = rsv && (rsv_rd != 0);
            n_tests++; if (outa !== ea) begin n_fail++; $display("FAIL rnd_outa[%0d] ra=%0d: got %h want %h", n, ra, outa, ea); end
            n_tests++; if (outb !== eb) begin n_fail++; $display("FAIL rnd_outb[%0d] rb=%0d: got %h want %h", n, rb, outb, eb); end
            n_tests++; if (busy_a !== eba) begin n_fail++; $display("FAIL rnd_busy_a[%0d] ra=%0d: got %b want %b", n, ra, busy_a, eba); end
            n_tests++; if (busy_b !== ebb) begin n_fail++; $display("FAIL rnd_busy_b[%0d] rb=%0d: got %b want %b", n, rb, busy_b, ebb); end
            n_tests++; if (rsv_ok !== eok) begin n_fail++; $display("FAIL rnd_rsv_ok[%0d]: got %b want %b", n, rsv_ok, eok); end
            model_edge();
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        fill_all();
        for (int i = 0; i < 4; i++) begin
            rsv = 1; rsv_rd = AW'($urandom_range(NREG - 1, 1));
            model_edge();
            tick();
        end
        idle_inputs();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int k = 0; k < NREG + 3; k++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) begin done_cnt++; done_at = k; end
            if (k >= 1 && k <= NREG - 2) begin
                ra = AW'(k); rb = AW'(k + 1);
                #1;
                n_tests++; if (outa !== '0) begin n_fail++; $display("FAIL clr_swept x%0d: got %h want 0", k, outa); end
                n_tests++; if (outb !== m_regs[k + 1]) begin n_fail++; $display("FAIL clr_pending x%0d: got %h want %h", k + 1, outb, m_regs[k + 1]); end
                n_tests++; if (busy_b !== 0) begin n_fail++; $display("FAIL clr_busy_bit x%0d: got %b want 0", k + 1, busy_b); end
            end
            if (k == 10) begin
                regwr = 1; rw = 4; wrdata = 32'hCAFE0004;
                rsv = 1; rsv_rd = 9;
                #1;
                n_tests++; if (rsv_ok !== 0) begin n_fail++; $display("FAIL clr_rsv_ok: got %b want 0", rsv_ok); end
            end
            if (k == 11) idle_inputs();
            tick();
        end
        n_tests++; if (busy_cnt != NREG) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want %0d", busy_cnt, NREG); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL clr_done_count: got %0d want 1", done_cnt); end
        n_tests++; if (done_at != NREG - 1) begin n_fail++; $display("FAIL clr_done_time: got %0d want %0d", done_at, NREG - 1); end
        model_zero();
        for (int i = 0; i < NREG; i++) begin
            ra = AW'(i);
            #1;
            n_tests++; if (outa !== m_regs[i]) begin n_fail++; $display("FAIL clr_final x%0d: got %h want %h", i, outa, m_regs[i]); end
            n_tests++; if (busy_a !== m_busy[i]) begin n_fail++; $display("FAIL clr_final_busy x%0d: got %b want 0", i, busy_a); end
        end
        rsv = 1; rsv_rd = 2;
        #1;
        n_tests++; if (rsv_ok !== 1) begin n_fail++; $display("FAIL clr_idle_again: got %b want 1", rsv_ok); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt = 0;
        fill_all();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (10) tick();
        n_tests++; if (clr_busy !== 1) begin n_fail++; $display("FAIL rms_sweeping: got %b want 1", clr_busy); end
        rst_n = 0;
        ra = 20;
        #1;
        n_tests++; if (clr_busy !== 0) begin n_fail++; $display("FAIL rms_async: got %b want 0", clr_busy); end
        n_tests++; if (outa !== '0) begin n_fail++; $display("FAIL rms_x20: got %h want 0", outa); end
        model_zero();
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            if (clr_done === 1'b1) done_cnt++;
            ra = AW'(i % NREG);
            #1;
            n_tests++; if (outa !== m_regs[i % NREG]) begin n_fail++; $display("FAIL rms_reg x%0d: got %h want 0", i % NREG, outa); end
            tick();
        end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL rms_no_done: got %0d pulses want 0", done_cnt); end
        n_tests++; if (clr_busy !== 0) begin n_fail++; $display("FAIL rms_idle: got %b want 0", clr_busy); end
    endtask

    initial begin
        ra = '0; rb = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_rsv_zero();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
